// File: rtl/coin_pkg.sv
// Shared types and constants for the coin acceptor: FSM states, held coin type,
// debounce default and a saturating counter helper.
package coin_pkg;

  localparam int unsigned DebounceDefault = 4;
  localparam int unsigned CntW            = 4;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StIssue,
    StReject,
    StRelease
  } state_e;

  // Encoding matches the {s10, s5} sample pattern so a held type compares directly.
  typedef enum logic [1:0] {
    CoinNone = 2'b00,
    CoinC5   = 2'b01,
    CoinC10  = 2'b10
  } coin_e;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] cnt);
    return (cnt == {CntW{1'b1}}) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/coin_sync.sv
// Two-flop synchronizer for one asynchronous sensor line.
module coin_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces two synchronized coin sensors and issues one credit or
// reject pulse per insertion, then waits for the slot to stay clear.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DebounceDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic sense5_raw,
  input  logic sense10_raw,
  input  logic inhibit,
  output logic coin5,
  output logic coin10,
  output logic reject,
  output logic busy
);

  localparam logic [CntW-1:0] DebCnt = CntW'(DEBOUNCE);

  logic            w_s5;
  logic            w_s10;
  logic [1:0]      w_pat;
  state_e          r_state;
  coin_e           r_type;
  logic [CntW-1:0] r_cnt;
  logic            r_coin5;
  logic            r_coin10;
  logic            r_reject;
  logic            r_busy;

  coin_sync u_sync5 (
    .clk (clk),
    .rst (rst),
    .d   (sense5_raw),
    .q   (w_s5)
  );

  coin_sync u_sync10 (
    .clk (clk),
    .rst (rst),
    .d   (sense10_raw),
    .q   (w_s10)
  );

  assign w_pat = {w_s10, w_s5};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_type   <= CoinNone;
      r_cnt    <= '0;
      r_coin5  <= 1'b0;
      r_coin10 <= 1'b0;
      r_reject <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_coin5  <= 1'b0;
      r_coin10 <= 1'b0;
      r_reject <= 1'b0;
      r_busy   <= 1'b1;
      unique case (r_state)
        StIdle: begin
          r_cnt  <= '0;
          r_busy <= 1'b0;
          if (w_pat == 2'b11) begin
            r_state  <= StReject;
            r_type   <= CoinNone;
            r_reject <= 1'b1;
            r_busy   <= 1'b1;
          end else if (w_pat != 2'b00) begin
            r_state <= StSettle;
            r_type  <= coin_e'(w_pat);
            r_cnt   <= CntW'(1);
            r_busy  <= 1'b1;
          end
        end
        StSettle: begin
          if (w_pat == 2'b00) begin
            // Glitch: coin never qualified, return silently.
            r_state <= StIdle;
            r_type  <= CoinNone;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (w_pat != r_type) begin
            r_state  <= StReject;
            r_reject <= 1'b1;
          end else if (r_cnt == DebCnt) begin
            if (!inhibit) begin
              r_state  <= StIssue;
              r_coin5  <= (r_type == CoinC5);
              r_coin10 <= (r_type == CoinC10);
            end else begin
              r_state  <= StReject;
              r_reject <= 1'b1;
            end
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        StIssue, StReject: begin
          r_state <= StRelease;
          r_cnt   <= '0;
        end
        StRelease: begin
          if (r_cnt == DebCnt) begin
            r_state <= StIdle;
            r_type  <= CoinNone;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (w_pat != 2'b00) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        default: begin
          r_state <= StIdle;
          r_type  <= CoinNone;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign coin5  = r_coin5;
  assign coin10 = r_coin10;
  assign reject = r_reject;
  assign busy   = r_busy;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor at DEBOUNCE=4. Step i is rising edge i after a
// scenario starts; the raw level set before step i is sampled on that edge.
module tb_coin_acceptor;

  logic clk         = 1'b0;
  logic rst         = 1'b1;
  logic sense5_raw  = 1'b0;
  logic sense10_raw = 1'b0;
  logic inhibit     = 1'b0;
  logic coin5;
  logic coin10;
  logic reject;
  logic busy;

  int n_err = 0;
  int n_chk = 0;
  int cyc, n5, n10, nrej, f5, f10, frej, excl;

  coin_acceptor #(
    .DEBOUNCE (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sense5_raw  (sense5_raw),
    .sense10_raw (sense10_raw),
    .inhibit     (inhibit),
    .coin5       (coin5),
    .coin10      (coin10),
    .reject      (reject),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cyc = 0; n5 = 0; n10 = 0; nrej = 0; f5 = -1; f10 = -1; frej = -1; excl = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (coin5)  begin n5++;   if (f5 < 0)   f5 = cyc;   end
    if (coin10) begin n10++;  if (f10 < 0)  f10 = cyc;  end
    if (reject) begin nrej++; if (frej < 0) frej = cyc; end
    if (int'(coin5) + int'(coin10) + int'(reject) > 1) excl++;
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b0;
    #1 check("reset_outs", {coin5, coin10, reject, busy}, 0);
    repeat (3) step();
    check("reset_busy_held", busy, 0);
    rst = 1'b1;

    // 5-coin held 10 cycles: s5 first high after step 2, pulse registered at step 7
    clr();
    for (int i = 1; i <= 25; i++) begin
      sense5_raw = (i <= 10);
      step();
      if (i == 2)  check("c5_busy_s2", busy, 0);
      if (i == 3)  check("c5_busy_s3", busy, 1);
      if (i == 7)  check("c5_pulse_s7", coin5, 1);
      if (i == 16) check("c5_busy_s16", busy, 1);
      if (i == 17) check("c5_busy_s17", busy, 0);
    end
    check("c5_count", n5, 1);
    check("c5_first", f5, 7);
    check("c5_no_other", n10 + nrej, 0);

    // 10-coin glitch of 3 cycles: no pulse, back to idle
    clr();
    for (int i = 1; i <= 15; i++) begin
      sense10_raw = (i <= 3);
      step();
      if (i == 5) check("glitch_busy_s5", busy, 1);
      if (i == 6) check("glitch_busy_s6", busy, 0);
    end
    check("glitch_pulses", n5 + n10 + nrej, 0);

    // Both sensors together: single reject
    clr();
    for (int i = 1; i <= 20; i++) begin
      sense5_raw  = (i <= 4);
      sense10_raw = (i <= 4);
      step();
    end
    check("both_rej_count", nrej, 1);
    check("both_rej_first", frej, 3);
    check("both_no_credit", n5 + n10, 0);
    check("both_idle", busy, 0);

    // 10-coin with inhibit only on the decision edge: reject instead of credit
    clr();
    for (int i = 1; i <= 25; i++) begin
      sense10_raw = (i <= 10);
      inhibit     = (i == 7);
      step();
    end
    inhibit = 1'b0;
    check("inh_rej_first", frej, 7);
    check("inh_rej_count", nrej, 1);
    check("inh_no_c10", n10, 0);

    // Inhibit high everywhere except the decision edge is ignored
    clr();
    for (int i = 1; i <= 25; i++) begin
      sense5_raw = (i <= 10);
      inhibit    = (i != 7);
      step();
    end
    inhibit = 1'b0;
    check("inh_ign_c5_first", f5, 7);
    check("inh_ign_rej", nrej, 0);

    // 5-coin held 30 cycles with a one-sample bounce during release
    clr();
    for (int i = 1; i <= 45; i++) begin
      sense5_raw = (i <= 30) && (i != 13);
      step();
    end
    check("bounce_c5_count", n5, 1);
    check("bounce_other", n10 + nrej, 0);
    check("bounce_idle", busy, 0);

    // Reset during SETTLE
    clr();
    sense5_raw = 1'b1;
    repeat (4) step();
    check("rst_settle_busy_pre", busy, 1);
    rst = 1'b0;
    #1 check("rst_settle_outs", {coin5, coin10, reject, busy}, 0);
    sense5_raw = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    clr();
    repeat (20) step();
    check("rst_settle_no_pulse", n5 + n10 + nrej, 0);

    // Reset during ISSUE
    clr();
    sense10_raw = 1'b1;
    repeat (7) step();
    check("rst_issue_c10_pre", coin10, 1);
    rst = 1'b0;
    #1 check("rst_issue_outs", {coin5, coin10, reject, busy}, 0);
    sense10_raw = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    clr();
    repeat (20) step();
    check("rst_issue_no_pulse", n5 + n10 + nrej, 0);

    // Sensor already high when reset releases: full latency from release
    rst = 1'b0;
    sense5_raw = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    clr();
    repeat (20) step();
    check("rst_rel_c5_first", f5, 7);
    check("rst_rel_c5_count", n5, 1);
    sense5_raw = 1'b0;
    repeat (15) step();
    check("rst_rel_idle", busy, 0);
    check("excl_last", excl, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
